// File: rtl/countdown_timer_if.sv
// Host-side bundle for countdown_timer: load handshake, run controls and count/status readback.
interface countdown_timer_if;
  logic       load_valid;
  logic       load_ready;
  logic [2:0] load_hour;
  logic [3:0] load_min;
  logic [4:0] load_sec;
  logic       start;
  logic       pause;
  logic       tick;
  logic [2:0] hour;
  logic [3:0] min;
  logic [4:0] sec;
  logic       busy;
  logic       done;
  logic       load_err;
  logic [1:0] state;

  modport master (
    output load_valid, load_hour, load_min, load_sec, start, pause, tick,
    input  load_ready, hour, min, sec, busy, done, load_err, state
  );

  modport slave (
    input  load_valid, load_hour, load_min, load_sec, start, pause, tick,
    output load_ready, hour, min, sec, busy, done, load_err, state
  );
endinterface

// File: rtl/countdown_timer.sv
// Mixed-radix hour:min:sec down-counter with load handshake and start/pause control.
// Define COUNTDOWN_AUTO_RELOAD_EN to restart from the last accepted load on expiry.
module countdown_timer #(
  parameter int unsigned SEC_MAX  = 20,
  parameter int unsigned MIN_MAX  = 10,
  parameter int unsigned HOUR_MAX = 5
) (
  input  logic              clk,
  input  logic              rst,
  countdown_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StPaused  = 2'd2,
    StExpired = 2'd3
  } state_e;

  localparam logic [2:0] HourMax = 3'(HOUR_MAX);
  localparam logic [3:0] MinMax  = 4'(MIN_MAX);
  localparam logic [4:0] SecMax  = 5'(SEC_MAX);

  state_e     r_state, w_state_nxt;
  logic [2:0] r_hour, w_hour_nxt;
  logic [3:0] r_min, w_min_nxt;
  logic [4:0] r_sec, w_sec_nxt;
  logic       r_busy;
  logic       r_load_ready;
  logic       r_done, w_done_nxt;
  logic       r_load_err, w_load_err_nxt;

  logic       w_load_fire;
  logic       w_load_ok;
  logic       w_count_zero;
  logic       w_count_one;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [2:0] r_shadow_hour, w_shadow_hour_nxt;
  logic [3:0] r_shadow_min, w_shadow_min_nxt;
  logic [4:0] r_shadow_sec, w_shadow_sec_nxt;
  logic       w_shadow_zero;

  assign w_shadow_zero = (r_shadow_hour == 3'd0) && (r_shadow_min == 4'd0) &&
                         (r_shadow_sec == 5'd0);
`endif

  // load_ready is registered and is low exactly in RUN, so it gates the handshake directly.
  assign w_load_fire  = bus.load_valid && r_load_ready;
  assign w_load_ok    = (bus.load_hour <= HourMax) && (bus.load_min <= MinMax) &&
                        (bus.load_sec <= SecMax);
  assign w_count_zero = (r_hour == 3'd0) && (r_min == 4'd0) && (r_sec == 5'd0);
  assign w_count_one  = (r_hour == 3'd0) && (r_min == 4'd0) && (r_sec == 5'd1);

  always_comb begin
    w_state_nxt    = r_state;
    w_hour_nxt     = r_hour;
    w_min_nxt      = r_min;
    w_sec_nxt      = r_sec;
    w_done_nxt     = 1'b0;
    w_load_err_nxt = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    w_shadow_hour_nxt = r_shadow_hour;
    w_shadow_min_nxt  = r_shadow_min;
    w_shadow_sec_nxt  = r_shadow_sec;
`endif

    if (w_load_fire) begin
      // A load attempt, accepted or rejected, swallows any start in the same cycle.
      if (w_load_ok) begin
        w_hour_nxt  = bus.load_hour;
        w_min_nxt   = bus.load_min;
        w_sec_nxt   = bus.load_sec;
        w_state_nxt = StIdle;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        w_shadow_hour_nxt = bus.load_hour;
        w_shadow_min_nxt  = bus.load_min;
        w_shadow_sec_nxt  = bus.load_sec;
`endif
      end else begin
        w_load_err_nxt = 1'b1;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.start && !w_count_zero) begin
            w_state_nxt = StRun;
          end
        end
        StRun: begin
          if (bus.pause) begin
            w_state_nxt = StPaused;
          end else if (bus.tick) begin
            if (w_count_one) begin
              w_done_nxt = 1'b1;
              w_sec_nxt  = 5'd0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              if (!w_shadow_zero) begin
                w_hour_nxt = r_shadow_hour;
                w_min_nxt  = r_shadow_min;
                w_sec_nxt  = r_shadow_sec;
              end else begin
                w_state_nxt = StExpired;
              end
`else
              w_state_nxt = StExpired;
`endif
            end else if (r_sec != 5'd0) begin
              w_sec_nxt = r_sec - 5'd1;
            end else if (r_min != 4'd0) begin
              w_min_nxt = r_min - 4'd1;
              w_sec_nxt = SecMax;
            end else if (r_hour != 3'd0) begin
              w_hour_nxt = r_hour - 3'd1;
              w_min_nxt  = MinMax;
              w_sec_nxt  = SecMax;
            end
          end
        end
        StPaused: begin
          if (bus.start) begin
            w_state_nxt = StRun;
          end
        end
        StExpired: begin
          w_state_nxt = StExpired;
        end
        default: begin
          w_state_nxt = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_hour       <= 3'd0;
      r_min        <= 4'd0;
      r_sec        <= 5'd0;
      r_busy       <= 1'b0;
      r_load_ready <= 1'b1;
      r_done       <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_hour       <= w_hour_nxt;
      r_min        <= w_min_nxt;
      r_sec        <= w_sec_nxt;
      r_busy       <= (w_state_nxt == StRun);
      r_load_ready <= (w_state_nxt != StRun);
      r_done       <= w_done_nxt;
      r_load_err   <= w_load_err_nxt;
    end
  end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow_hour <= 3'd0;
      r_shadow_min  <= 4'd0;
      r_shadow_sec  <= 5'd0;
    end else begin
      r_shadow_hour <= w_shadow_hour_nxt;
      r_shadow_min  <= w_shadow_min_nxt;
      r_shadow_sec  <= w_shadow_sec_nxt;
    end
  end
`endif

  assign bus.load_ready = r_load_ready;
  assign bus.hour       = r_hour;
  assign bus.min        = r_min;
  assign bus.sec        = r_sec;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.load_err   = r_load_err;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios with literal expectations, then random
// stimulus checked every cycle against a total-seconds model of the countdown.
module tb_countdown_timer;

  localparam int SecPerMin  = 21;   // sec runs 0..20
  localparam int SecPerHour = 231;  // 11 minutes of 21 seconds
  localparam int StIdle = 0, StRun = 1, StPaused = 2, StExpired = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  countdown_timer_if u_if ();

  countdown_timer u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: count held as total seconds remaining.
  int m_total  = 0;
  int m_shadow = 0;
  int m_state  = StIdle;
  bit m_done   = 1'b0;
  bit m_err    = 1'b0;
  bit m_valid  = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    m_done = 1'b0;
    m_err  = 1'b0;
    if (rst) begin
      m_total  = 0;
      m_shadow = 0;
      m_state  = StIdle;
      m_valid  = 1'b1;
    end else if (u_if.load_valid && m_state != StRun) begin
      if (u_if.load_hour <= 5 && u_if.load_min <= 10 && u_if.load_sec <= 20) begin
        m_total  = u_if.load_hour * SecPerHour + u_if.load_min * SecPerMin + u_if.load_sec;
        m_shadow = m_total;
        m_state  = StIdle;
      end else begin
        m_err = 1'b1;
      end
    end else begin
      case (m_state)
        StIdle:   if (u_if.start && m_total != 0) m_state = StRun;
        StPaused: if (u_if.start) m_state = StRun;
        StRun: begin
          if (u_if.pause) begin
            m_state = StPaused;
          end else if (u_if.tick) begin
            m_total = m_total - 1;
            if (m_total == 0) begin
              m_done = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              if (m_shadow != 0) m_total = m_shadow;
              else m_state = StExpired;
`else
              m_state = StExpired;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("hour", int'(u_if.hour), m_total / SecPerHour);
      chk("min", int'(u_if.min), (m_total % SecPerHour) / SecPerMin);
      chk("sec", int'(u_if.sec), m_total % SecPerMin);
      chk("state", int'(u_if.state), m_state);
      chk("busy", int'(u_if.busy), int'(m_state == StRun));
      chk("load_ready", int'(u_if.load_ready), int'(m_state != StRun));
      chk("done", int'(u_if.done), int'(m_done));
      chk("load_err", int'(u_if.load_err), int'(m_err));
    end
  end

  task automatic step(input bit lv, input int h, input int m, input int s,
                      input bit st, input bit pa, input bit tk);
    @(negedge clk);
    u_if.load_valid = lv;
    u_if.load_hour  = 3'(h);
    u_if.load_min   = 4'(m);
    u_if.load_sec   = 5'(s);
    u_if.start      = st;
    u_if.pause      = pa;
    u_if.tick       = tk;
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst = 1'b1;
    u_if.load_valid = 1'b0;
    u_if.start = 1'b0;
    u_if.pause = 1'b0;
    u_if.tick  = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_count(input string nm, input int h, input int m, input int s);
    chk({nm, ".hour"}, int'(u_if.hour), h);
    chk({nm, ".min"}, int'(u_if.min), m);
    chk({nm, ".sec"}, int'(u_if.sec), s);
  endtask

  initial begin
    int n;
    u_if.load_valid = 1'b0;
    u_if.load_hour  = '0;
    u_if.load_min   = '0;
    u_if.load_sec   = '0;
    u_if.start      = 1'b0;
    u_if.pause      = 1'b0;
    u_if.tick       = 1'b0;
    do_rst();
    chk_count("reset", 0, 0, 0);
    chk("reset.state", int'(u_if.state), StIdle);
    chk("reset.ready", int'(u_if.load_ready), 1);

    // 0:0:3 counts 3,2,1,0 with done on the 0 cycle.
    step(1, 0, 0, 3, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 1);
    chk("t1.sec0", int'(u_if.sec), 3);
    chk("t1.busy", int'(u_if.busy), 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("t1.sec1", int'(u_if.sec), 2);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("t1.sec2", int'(u_if.sec), 1);
    chk("t1.nodone", int'(u_if.done), 0);
    step(0, 0, 0, 0, 0, 0, 1);
`ifndef COUNTDOWN_AUTO_RELOAD_EN
    chk("t1.sec3", int'(u_if.sec), 0);
    chk("t1.done", int'(u_if.done), 1);
    chk("t1.state", int'(u_if.state), StExpired);
    chk("t1.busy_end", int'(u_if.busy), 0);
    step(0, 0, 0, 0, 1, 0, 1);
    chk("t1.done_once", int'(u_if.done), 0);
    chk("t1.start_ign", int'(u_if.state), StExpired);

    // 1:0:0 takes 231 ticks; first tick borrows all the way down.
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk_count("t2.borrow", 0, 10, 20);
    n = 1;
    while (u_if.done !== 1'b1 && n < 300) begin
      step(0, 0, 0, 0, 0, 0, 1);
      n++;
    end
    chk("t2.ticks_to_done", n, 231);
`endif

    // Pause beats tick; paused count is frozen; resume continues.
    do_rst();
    step(1, 0, 2, 5, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    chk_count("t3.paused", 0, 2, 3);
    chk("t3.state", int'(u_if.state), StPaused);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 1);
    chk_count("t3.frozen", 0, 2, 3);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk_count("t3.resume", 0, 2, 2);

    // Out-of-range loads rejected in PAUSED; loads ignored in RUN.
    step(0, 0, 0, 0, 0, 1, 0);
    step(1, 6, 0, 0, 0, 0, 0);
    chk("t4.err_h", int'(u_if.load_err), 1);
    chk_count("t4.keep_h", 0, 2, 2);
    chk("t4.state_h", int'(u_if.state), StPaused);
    step(1, 0, 11, 0, 0, 0, 0);
    chk("t4.err_m", int'(u_if.load_err), 1);
    step(1, 0, 0, 21, 0, 0, 0);
    chk("t4.err_s", int'(u_if.load_err), 1);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("t4.err_clr", int'(u_if.load_err), 0);
    chk("t4.ready_run", int'(u_if.load_ready), 0);
    step(1, 0, 0, 1, 0, 0, 0);
    chk_count("t4.run_ignore", 0, 2, 2);
    chk("t4.run_noerr", int'(u_if.load_err), 0);

    // Zero load: start does nothing.
    step(0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 1);
    chk("t5.zero_idle", int'(u_if.state), StIdle);
    chk("t5.zero_nodone", int'(u_if.done), 0);

    // Reset mid-run.
    step(1, 0, 5, 7, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("t5.run", int'(u_if.state), StRun);
    do_rst();
    chk_count("t5.rst", 0, 0, 0);
    chk("t5.rst_state", int'(u_if.state), StIdle);
    chk("t5.rst_done", int'(u_if.done), 0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    step(1, 0, 0, 2, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("ar.sec1", int'(u_if.sec), 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("ar.reload", int'(u_if.sec), 2);
    chk("ar.done", int'(u_if.done), 1);
    chk("ar.state", int'(u_if.state), StRun);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("ar.sec_again", int'(u_if.sec), 1);
    chk("ar.ready", int'(u_if.load_ready), 0);
`endif

    // Random traffic; the negedge compare process checks every cycle.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_rst();
      end else begin
        step($urandom_range(0, 15) == 0,
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : 0,
             int'($urandom_range(0, 3)) + (($urandom_range(0, 9) == 0) ? 9 : 0),
             int'($urandom_range(0, 22)),
             $urandom_range(0, 5) == 0,
             $urandom_range(0, 15) == 0,
             $urandom_range(0, 3) != 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
